// File: rtl/rb_dump_unit_pkg.sv
// Shared debug-unit definitions: FSM encodings and word/byte geometry helpers.
// Reused by the PC and memory dump units.
package rb_dump_unit_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_READ    = 3'd1;
  localparam logic [ST_W-1:0] ST_CAPTURE = 3'd2;
  localparam logic [ST_W-1:0] ST_SEND    = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_TX = 3'd4;
  localparam logic [ST_W-1:0] ST_NEXT    = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd6;

  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_dump_unit_if.sv
// Bundle between the dump unit, the register-bank debug port and the UART TX.
// Signal names are seen from the dump unit; slave = dump unit, master = its environment.
interface rb_dump_unit_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
);

  logic               i_start;
  logic [NB_DATA-1:0] i_reg_data;
  logic               i_tx_done;
  logic               o_read_enable;
  logic [NB_ADDR-1:0] o_read_address;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_reg_data, i_tx_done,
    output o_read_enable, o_read_address, o_tx_start, o_tx_data, o_busy, o_done
  );

  modport master (
    output i_start, i_reg_data, i_tx_done,
    input  o_read_enable, o_read_address, o_tx_start, o_tx_data, o_busy, o_done
  );

endinterface

// File: rtl/rb_dump_unit_word_serializer.sv
// Holds the captured word and feeds it MSB byte first to the UART, one byte per
// SEND/WAIT_TX round trip. The top FSM owns the state; this block decodes it.
module rb_dump_unit_word_serializer
  import rb_dump_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [ST_W-1:0]    i_state,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_last_byte
);

  localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int CNT_W = cnt_width(BPW);

  logic [NB_DATA-1:0] shift_reg;
  logic [CNT_W-1:0]   byte_cnt;
  logic               advance;

  assign o_last_byte = (byte_cnt == CNT_W'(BPW - 1));
  assign advance     = (i_state == ST_WAIT_TX) && i_tx_done && !o_last_byte;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (i_state == ST_CAPTURE) begin
      shift_reg <= i_word;
      byte_cnt  <= '0;
    end else if (advance) begin
      shift_reg <= shift_reg << NB_BYTE;
      byte_cnt  <= byte_cnt + 1'b1;
    end
  end

  // The outgoing byte always sits in the top lane, so it is stable across WAIT_TX.
  assign o_tx_start = (i_state == ST_SEND);
  assign o_tx_data  = shift_reg[NB_DATA-1 -: NB_BYTE];

endmodule

// File: rtl/rb_dump_unit.sv
// Register-bank dump: walks the bank debug port 0..BANK_DEPTH-1 and streams each
// word to the UART transmitter through the word serializer.
module rb_dump_unit
  import rb_dump_unit_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  rb_dump_unit_if.slave bus
);

  logic [ST_W-1:0]    state, state_nxt;
  logic [NB_ADDR-1:0] reg_idx;
  logic               last_reg;
  logic               last_byte;
  logic               rd_en;

  // Terminal compare happens before any increment, so reg_idx never wraps.
  assign last_reg = (reg_idx == NB_ADDR'(BANK_DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.i_start) state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_SEND;
      ST_SEND:    state_nxt = ST_WAIT_TX;
      ST_WAIT_TX: if (bus.i_tx_done) state_nxt = last_byte ? ST_NEXT : ST_SEND;
      ST_NEXT:    state_nxt = last_reg ? ST_DONE : ST_READ;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      reg_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.i_start)
        reg_idx <= '0;
      else if (state == ST_NEXT && !last_reg)
        reg_idx <= reg_idx + 1'b1;
    end
  end

  rb_dump_unit_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_state     (state),
    .i_word      (bus.i_reg_data),
    .i_tx_done   (bus.i_tx_done),
    .o_tx_start  (bus.o_tx_start),
    .o_tx_data   (bus.o_tx_data),
    .o_last_byte (last_byte)
  );

  // Address held through CAPTURE so a registered bank returns data there.
  assign rd_en = (state == ST_READ) || (state == ST_CAPTURE);

  always_comb begin
    bus.o_read_enable  = rd_en;
    bus.o_read_address = rd_en ? reg_idx : '0;
    bus.o_busy         = (state != ST_IDLE);
    bus.o_done         = (state == ST_DONE);
  end

endmodule

// File: tb/tb_rb_dump_unit.sv
// Directed bench for rb_dump_unit with a registered bank model and a UART model
// that returns tx_done a programmable number of cycles after each tx_start.
module tb_rb_dump_unit;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;

  always #5 i_clock = ~i_clock;

  rb_dump_unit_if #(.NB_DATA(32), .NB_ADDR(5), .NB_BYTE(8)) rb ();

  rb_dump_unit #(
    .NB_DATA(32), .NB_ADDR(5), .BANK_DEPTH(32), .NB_BYTE(8)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (rb.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // environment model state
  bit         last_re = 1'b0;
  logic [4:0] last_addr = '0;
  int         re_len = 0;
  bit         pend = 1'b0;
  int         cnt = 0;
  int         dly = 1;
  logic [7:0] held = '0;
  bit         spur_idle = 1'b0;
  bit         spur_dump = 1'b0;
  bit         in_dump = 1'b0;
  bit         done_prev = 1'b0;
  int         nbytes = 0;
  int         addr_seq = 0;
  int         inv_err = 0;
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bank_val(input logic [4:0] a);
    return 32'hA0B1C2D0 + 32'(a);
  endfunction

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = 32'hA0B1C2D0 + 32'(n / 4);
    return w[31 - 8 * (n % 4) -: 8];
  endfunction

  task automatic step();
    bit tx_model;
    @(posedge i_clock);
    #1;
    rb.i_reg_data = last_re ? bank_val(last_addr) : 32'hDEADBEEF;
    if (rb.o_read_enable) begin
      if (!last_re) begin
        check($sformatf("addr%0d", addr_seq), 32'(rb.o_read_address), 32'(addr_seq));
        addr_seq++;
        re_len = 0;
      end else if (rb.o_read_address != last_addr) inv_err++;
      re_len++;
    end else begin
      if (rb.o_read_address != '0) inv_err++;
      if (last_re && re_len != 2) inv_err++;
    end
    last_re   = rb.o_read_enable;
    last_addr = rb.o_read_address;
    if (rb.o_read_enable && rb.o_tx_start) inv_err++;
    if (in_dump != rb.o_busy) inv_err++;
    if (rb.o_done && done_prev) inv_err++;
    done_prev = rb.o_done;
    if (rb.o_done) in_dump = 1'b0;
    if (pend && rb.o_tx_start) inv_err++;
    if (pend && rb.o_tx_data != held) inv_err++;
    tx_model = 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        tx_model = 1'b1;
        pend = 1'b0;
      end else cnt--;
    end
    if (rb.o_tx_start) begin
      check($sformatf("byte%0d", nbytes), 32'(rb.o_tx_data), 32'(exp_byte(nbytes)));
      nbytes++;
      held = rb.o_tx_data;
      pend = 1'b1;
      cnt  = dly;
    end
    rb.i_tx_done = tx_model | spur_idle | (spur_dump & (rb.o_read_enable | rb.o_tx_start));
  endtask

  task automatic run_dump(input int d, input bit mid, input bit spur, input bit abort);
    dly = d; spur_dump = spur; nbytes = 0; addr_seq = 0; inv_err = 0;
    pend = 1'b0; done_prev = 1'b0;
    rb.i_start = 1'b1;
    in_dump = 1'b1;
    step();
    rb.i_start = 1'b0;
    cyc = 0;
    while (!rb.o_done && cyc < 4000) begin
      step();
      cyc++;
      rb.i_start = mid && rb.o_read_enable && (rb.o_read_address == 5'd7);
      if (abort && nbytes == 50 && pend && !rb.o_tx_start) break;
    end
    rb.i_start = 1'b0;
    if (!abort) begin
      check("done_seen", 32'(rb.o_done), 32'd1);
      step();
      check("done_pulse", 32'(rb.o_done), 32'd0);
      check("idle_busy", 32'(rb.o_busy), 32'd0);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_busy"}, 32'(rb.o_busy), 32'd0);
    check({pfx, "_done"}, 32'(rb.o_done), 32'd0);
    check({pfx, "_re"},   32'(rb.o_read_enable), 32'd0);
    check({pfx, "_addr"}, 32'(rb.o_read_address), 32'd0);
    check({pfx, "_txs"},  32'(rb.o_tx_start), 32'd0);
    check({pfx, "_txd"},  32'(rb.o_tx_data), 32'd0);
  endtask

  initial begin
    rb.i_start = 1'b0;
    rb.i_tx_done = 1'b0;
    rb.i_reg_data = '0;
    #1 i_reset = 1'b1;
    #11;
    check_zero_outputs("rst");
    i_reset = 1'b0;

    // 1: nominal dump, tx_done on first WAIT_TX cycle
    run_dump(1, 1'b0, 1'b0, 1'b0);
    check("t1_cycles", 32'(cyc), 32'd352);
    check("t1_bytes", 32'(nbytes), 32'd128);
    check("t1_addrs", 32'(addr_seq), 32'd32);
    check("t1_inv", 32'(inv_err), 32'd0);

    // 2: slow UART, 5 wait cycles per byte
    run_dump(5, 1'b0, 1'b0, 1'b0);
    check("t2_cycles", 32'(cyc), 32'd864);
    check("t2_bytes", 32'(nbytes), 32'd128);
    check("t2_inv", 32'(inv_err), 32'd0);

    // 3: i_start re-pulsed while reg 7 is being read
    run_dump(1, 1'b1, 1'b0, 1'b0);
    check("t3_cycles", 32'(cyc), 32'd352);
    check("t3_bytes", 32'(nbytes), 32'd128);
    check("t3_addrs", 32'(addr_seq), 32'd32);
    check("t3_inv", 32'(inv_err), 32'd0);

    // 5: spurious tx_done in IDLE, then during READ/CAPTURE/SEND
    nbytes = 0; inv_err = 0;
    spur_idle = 1'b1;
    repeat (4) step();
    check("t5_idle_busy", 32'(rb.o_busy), 32'd0);
    spur_idle = 1'b0;
    step();
    check("t5_idle_bytes", 32'(nbytes), 32'd0);
    run_dump(1, 1'b0, 1'b1, 1'b0);
    spur_dump = 1'b0;
    check("t5_cycles", 32'(cyc), 32'd352);
    check("t5_bytes", 32'(nbytes), 32'd128);
    check("t5_inv", 32'(inv_err), 32'd0);

    // 4: async reset while waiting on the second byte of reg 12
    run_dump(3, 1'b0, 1'b0, 1'b1);
    check("t4_bytes_pre", 32'(nbytes), 32'd50);
    check("t4_txd_pre", 32'(rb.o_tx_data), 32'h0000_00B1);
    check("t4_busy_pre", 32'(rb.o_busy), 32'd1);
    i_reset = 1'b1;
    #1;
    check_zero_outputs("t4_rst");
    #2 i_reset = 1'b0;
    rb.i_tx_done = 1'b0;
    last_re = 1'b0; pend = 1'b0; in_dump = 1'b0; done_prev = 1'b0;
    step();
    check("t4_idle_busy", 32'(rb.o_busy), 32'd0);
    run_dump(1, 1'b0, 1'b0, 1'b0);
    check("t4_cycles", 32'(cyc), 32'd352);
    check("t4_bytes", 32'(nbytes), 32'd128);
    check("t4_addrs", 32'(addr_seq), 32'd32);
    check("t4_inv", 32'(inv_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
